// File: rtl/hps_fpga_mem_tester_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hps_fpga_mem_tester_pkg
// Description : Shared types and constants for the HPS/FPGA memory tester:
//               the top-level FSM state encoding and the error counter
//               width and saturation value, plus a saturating increment.
// Revision    : 1.0 - initial release
// ============================================================================
package hps_fpga_mem_tester_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int                 c_err_w   = 16;
    localparam logic [c_err_w-1:0] c_err_sat = 16'hFFFF;
    localparam logic [c_err_w-1:0] c_err_one = 16'h0001;

    // Error counter increment that sticks at the maximum value.
    function automatic logic [c_err_w-1:0] err_sat_inc(input logic [c_err_w-1:0] v);
        return (v == c_err_sat) ? v : (v + c_err_one);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hps_fpga_mem_tester_cmp.sv
`default_nettype none
// ============================================================================
// Module      : hps_fpga_mem_tester_cmp
// Description : Read-response checker. Counts in-order responses, compares
//               each against seed + response index and keeps a saturating
//               mismatch count.
// Ports       : clk, reset_n (sync, active-low), clear (new test),
//               seed (pattern base), rsp_valid/rsp_data (accepted response),
//               rsp_count (responses seen), err_count (mismatches).
//               With HPS_FPGA_MEM_TESTER_ERR_CAPTURE_EN: base (test base
//               address), first_err_addr/first_err_data (first mismatch).
// Revision    : 1.0 - initial release
// ============================================================================
module hps_fpga_mem_tester_cmp
    import hps_fpga_mem_tester_pkg::*;
#(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 64
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                clear,
    input  logic [DATA_W-1:0]   seed,
    input  logic                rsp_valid,
    input  logic [DATA_W-1:0]   rsp_data,
`ifdef HPS_FPGA_MEM_TESTER_ERR_CAPTURE_EN
    input  logic [ADDR_W-1:0]   base,
    output logic [ADDR_W-1:0]   first_err_addr,
    output logic [DATA_W-1:0]   first_err_data,
`endif
    output logic [ADDR_W:0]     rsp_count,
    output logic [c_err_w-1:0]  err_count
);

    localparam logic [ADDR_W:0] c_cnt_one = 1;

    logic [ADDR_W:0]    r_rsp_count;
    logic [c_err_w-1:0] r_err_count;
    logic [DATA_W-1:0]  w_expected;
    logic               w_mismatch;

    // Responses return in issue order, so the k-th response belongs to word k.
    assign w_expected = seed + DATA_W'(r_rsp_count);
    assign w_mismatch = rsp_valid && (rsp_data != w_expected);

    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            r_rsp_count <= '0;
            r_err_count <= '0;
        end else if (rsp_valid) begin
            r_rsp_count <= r_rsp_count + c_cnt_one;
            if (w_mismatch) begin
                r_err_count <= err_sat_inc(r_err_count);
            end
        end
    end

    assign rsp_count = r_rsp_count;
    assign err_count = r_err_count;

`ifdef HPS_FPGA_MEM_TESTER_ERR_CAPTURE_EN
    logic              r_have_err;
    logic [ADDR_W-1:0] r_first_err_addr;
    logic [DATA_W-1:0] r_first_err_data;

    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            r_have_err       <= 1'b0;
            r_first_err_addr <= '0;
            r_first_err_data <= '0;
        end else if (w_mismatch && !r_have_err) begin
            r_have_err       <= 1'b1;
            r_first_err_addr <= base + r_rsp_count[ADDR_W-1:0];
            r_first_err_data <= rsp_data;
        end
    end

    assign first_err_addr = r_first_err_addr;
    assign first_err_data = r_first_err_data;
`endif

endmodule
`default_nettype wire

// File: rtl/hps_fpga_mem_tester.sv
`default_nettype none
// ============================================================================
// Module      : hps_fpga_mem_tester
// Description : Avalon-MM memory tester. Writes seed+i to base+i for
//               num_words words, reads them back with up to MAX_PEND reads
//               in flight, and reports the mismatch count.
// Ports       : clk, reset_n (sync, active-low)
//               start/base_addr/num_words/seed : test launch (IDLE only)
//               busy/done/pass/err_count       : status and result
//               avm_*                          : Avalon-MM master
// Options     : HPS_FPGA_MEM_TESTER_ERR_CAPTURE_EN adds first_err_addr and
//               first_err_data (address/data of first mismatch per test).
// Revision    : 1.0 - initial release
// ============================================================================
module hps_fpga_mem_tester
    import hps_fpga_mem_tester_pkg::*;
#(
    parameter int ADDR_W   = 13,
    parameter int DATA_W   = 64,
    parameter int MAX_PEND = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W:0]     num_words,
    input  logic [DATA_W-1:0]   seed,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [c_err_w-1:0]  err_count,
`ifdef HPS_FPGA_MEM_TESTER_ERR_CAPTURE_EN
    output logic [ADDR_W-1:0]   first_err_addr,
    output logic [DATA_W-1:0]   first_err_data,
`endif
    output logic [ADDR_W-1:0]   avm_address,
    output logic                avm_chipselect,
    output logic                avm_read,
    output logic                avm_write,
    output logic [DATA_W/8-1:0] avm_byteenable,
    output logic [DATA_W-1:0]   avm_writedata,
    input  logic [DATA_W-1:0]   avm_readdata,
    input  logic                avm_waitrequest,
    input  logic                avm_readdatavalid
);

    localparam int                CNT_W      = ADDR_W + 1;
    localparam int                PEND_W     = $clog2(MAX_PEND + 1);
    localparam int                BE_W       = DATA_W / 8;
    localparam logic [CNT_W-1:0]  c_cnt_one  = 1;
    localparam logic [PEND_W-1:0] c_pend_one = 1;
    localparam logic [PEND_W-1:0] c_pend_max = PEND_W'(MAX_PEND);

    state_t             r_state;
    state_t             w_next_state;

    logic [ADDR_W-1:0]  r_base;
    logic [CNT_W-1:0]   r_num;
    logic [DATA_W-1:0]  r_seed;
    logic [CNT_W-1:0]   r_idx;      // command index, shared by both phases
    logic [PEND_W-1:0]  r_pend;     // reads accepted but not yet answered
    logic               r_pass;

    logic               w_start_acc;
    logic               w_last_cmd;
    logic               w_wr_acc;
    logic               w_rd_acc;
    logic               w_rsp_valid;
    logic               w_all_rsp;
    logic [CNT_W-1:0]   w_rsp_cnt;
    logic [c_err_w-1:0] w_err_count;

    assign w_start_acc = start && (r_state == ST_IDLE);
    assign w_last_cmd  = (r_idx == (r_num - c_cnt_one));
    assign w_wr_acc    = avm_write && !avm_waitrequest;
    assign w_rd_acc    = avm_read && !avm_waitrequest;
    // Responses outside the read phases are stale (e.g. after a reset abort).
    assign w_rsp_valid = avm_readdatavalid && ((r_state == ST_READ) || (r_state == ST_DRAIN));
    assign w_all_rsp   = (w_rsp_cnt == r_num);

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_start_acc) begin
                    w_next_state = (num_words == '0) ? ST_DONE : ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (w_wr_acc && w_last_cmd) begin
                    w_next_state = ST_READ;
                end
            end
            ST_READ: begin
                if (w_rd_acc && w_last_cmd) begin
                    w_next_state = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_all_rsp) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        busy           = 1'b0;
        done           = 1'b0;
        avm_write      = 1'b0;
        avm_read       = 1'b0;
        unique case (r_state)
            ST_WRITE: begin
                busy      = 1'b1;
                avm_write = 1'b1;
            end
            ST_READ: begin
                busy     = 1'b1;
                // Once asserted, a stalled read stays asserted: r_pend can
                // only fall while the command waits.
                avm_read = (r_pend < c_pend_max);
            end
            ST_DRAIN: begin
                busy = 1'b1;
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
        avm_chipselect = avm_read || avm_write;
    end

    // Command fields derive from registered state only, so they stay stable
    // while waitrequest holds the transfer off.
    assign avm_address    = avm_chipselect ? (r_base + r_idx[ADDR_W-1:0]) : '0;
    assign avm_writedata  = avm_write ? (r_seed + DATA_W'(r_idx)) : '0;
    assign avm_byteenable = avm_chipselect ? {BE_W{1'b1}} : {BE_W{1'b0}};

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_base <= '0;
            r_num  <= '0;
            r_seed <= '0;
            r_idx  <= '0;
            r_pend <= '0;
        end else if (w_start_acc) begin
            r_base <= base_addr;
            r_num  <= num_words;
            r_seed <= seed;
            r_idx  <= '0;
            r_pend <= '0;
        end else begin
            if (w_wr_acc) begin
                // Rewind so the read phase starts at word 0 on the next cycle.
                r_idx <= w_last_cmd ? '0 : (r_idx + c_cnt_one);
            end else if (w_rd_acc) begin
                r_idx <= r_idx + c_cnt_one;
            end

            case ({w_rd_acc, w_rsp_valid})
                2'b10:   r_pend <= r_pend + c_pend_one;
                2'b01:   r_pend <= r_pend - c_pend_one;
                default: r_pend <= r_pend;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_pass <= 1'b0;
        end else if (w_start_acc) begin
            // An empty test goes straight to DONE and trivially passes.
            r_pass <= (num_words == '0);
        end else if ((r_state == ST_DRAIN) && w_all_rsp) begin
            r_pass <= (w_err_count == '0);
        end
    end

    assign pass      = r_pass;
    assign err_count = w_err_count;

    // ------------------------------------------------------------ checker
    hps_fpga_mem_tester_cmp #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_cmp (
        .clk            (clk),
        .reset_n        (reset_n),
        .clear          (w_start_acc),
        .seed           (r_seed),
        .rsp_valid      (w_rsp_valid),
        .rsp_data       (avm_readdata),
`ifdef HPS_FPGA_MEM_TESTER_ERR_CAPTURE_EN
        .base           (r_base),
        .first_err_addr (first_err_addr),
        .first_err_data (first_err_data),
`endif
        .rsp_count      (w_rsp_cnt),
        .err_count      (w_err_count)
    );

endmodule
`default_nettype wire

// File: tb/tb_hps_fpga_mem_tester.sv
`default_nettype none
// ============================================================================
// Module      : tb_hps_fpga_mem_tester
// Description : Directed self-checking bench for hps_fpga_mem_tester with an
//               Avalon-MM memory model (configurable read latency, random
//               waitrequest, optional single-bit read corruption).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hps_fpga_mem_tester;

    localparam int ADDR_W   = 13;
    localparam int DATA_W   = 64;
    localparam int MAX_PEND = 4;
    localparam int DEPTH    = 1 << ADDR_W;

    logic              clk;
    logic              reset_n;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   num_words;
    logic [DATA_W-1:0] seed;
    logic              busy, done, pass;
    logic [15:0]       err_count;
`ifdef HPS_FPGA_MEM_TESTER_ERR_CAPTURE_EN
    logic [ADDR_W-1:0] first_err_addr;
    logic [DATA_W-1:0] first_err_data;
`endif
    logic [ADDR_W-1:0] avm_address;
    logic              avm_chipselect, avm_read, avm_write;
    logic [7:0]        avm_byteenable;
    logic [DATA_W-1:0] avm_writedata;
    logic [DATA_W-1:0] avm_readdata;
    logic              avm_waitrequest;
    logic              avm_readdatavalid;

    hps_fpga_mem_tester #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MAX_PEND (MAX_PEND)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .start             (start),
        .base_addr         (base_addr),
        .num_words         (num_words),
        .seed              (seed),
        .busy              (busy),
        .done              (done),
        .pass              (pass),
        .err_count         (err_count),
`ifdef HPS_FPGA_MEM_TESTER_ERR_CAPTURE_EN
        .first_err_addr    (first_err_addr),
        .first_err_data    (first_err_data),
`endif
        .avm_address       (avm_address),
        .avm_chipselect    (avm_chipselect),
        .avm_read          (avm_read),
        .avm_write         (avm_write),
        .avm_byteenable    (avm_byteenable),
        .avm_writedata     (avm_writedata),
        .avm_readdata      (avm_readdata),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdatavalid (avm_readdatavalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------ checking
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // --------------------------------------------------------- memory model
    logic [DATA_W-1:0] mem [0:DEPTH-1];
    int                wr_hits [0:DEPTH-1];
    int                rd_hits [0:DEPTH-1];
    int                q_due[$];
    logic [DATA_W-1:0] q_data[$];

    int                cyc = 0;
    int                lat = 1;
    bit                wait_en = 1'b0;
    bit                flip_en = 1'b0;
    logic [ADDR_W-1:0] flip_addr = '0;
    logic [ADDR_W-1:0] exp_base = '0;
    logic [DATA_W-1:0] exp_seed = '0;
    int                pend = 0, max_pend = 0;
    int                wr_k = 0, rd_k = 0;
    int                bus_act = 0, proto_err = 0, done_cnt = 0;
    int                first_rd_cyc = 0, last_rd_cyc = 0, last_wr_cyc = 0;
    logic [ADDR_W-1:0] wr_log_addr [0:7];
    logic [DATA_W-1:0] wr_log_data [0:7];
    logic [ADDR_W-1:0] rd_log_addr [0:7];

    // Runs on the falling edge: it sets the memory's inputs for the next
    // rising edge, then records the transfer the DUT will see accepted there.
    always @(negedge clk) begin
        logic [ADDR_W-1:0] ea;
        logic [DATA_W-1:0] rd;
        cyc++;
        if ((q_due.size() > 0) && (q_due[0] == cyc)) begin
            avm_readdatavalid = 1'b1;
            avm_readdata      = q_data.pop_front();
            void'(q_due.pop_front());
            pend--;
        end else begin
            avm_readdatavalid = 1'b0;
            avm_readdata      = '0;
        end
        avm_waitrequest = wait_en && ($urandom_range(0, 2) == 0);

        if (done) done_cnt++;
        if (avm_read && avm_write) proto_err++;
        if (avm_chipselect !== (avm_read || avm_write)) proto_err++;
        if (avm_read || avm_write) bus_act++;

        if (avm_write && !avm_waitrequest) begin
            ea = exp_base + ADDR_W'(wr_k);
            check_val("wr_addr", 64'(avm_address), 64'(ea));
            check_val("wr_data", avm_writedata, exp_seed + 64'(wr_k));
            check_val("wr_be", 64'(avm_byteenable), 64'hFF);
            if (wr_k < 8) begin
                wr_log_addr[wr_k] = avm_address;
                wr_log_data[wr_k] = avm_writedata;
            end
            mem[avm_address] = avm_writedata;
            wr_hits[avm_address]++;
            last_wr_cyc = cyc;
            wr_k++;
        end

        if (avm_read && !avm_waitrequest) begin
            ea = exp_base + ADDR_W'(rd_k);
            check_val("rd_addr", 64'(avm_address), 64'(ea));
            if (rd_k < 8) rd_log_addr[rd_k] = avm_address;
            if (rd_k == 0) first_rd_cyc = cyc;
            last_rd_cyc = cyc;
            rd = mem[avm_address];
            if (flip_en && (avm_address == flip_addr)) rd[0] = ~rd[0];
            q_due.push_back(cyc + lat);
            q_data.push_back(rd);
            rd_hits[avm_address]++;
            pend++;
            if (pend > max_pend) max_pend = pend;
            rd_k++;
        end
    end

    // ---------------------------------------------------------- procedures
    task automatic start_test(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] n,
                              input logic [DATA_W-1:0] s);
        exp_base  = b;
        exp_seed  = s;
        flip_addr = b + 13'd3;
        wr_k = 0; rd_k = 0; max_pend = 0;
        bus_act = 0; proto_err = 0; done_cnt = 0;
        for (int i = 0; i < DEPTH; i++) begin
            wr_hits[i] = 0;
            rd_hits[i] = 0;
        end
        @(negedge clk);
        base_addr = b;
        num_words = n;
        seed      = s;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits for done; optionally fires a start pulse mid-test that must be ignored.
    task automatic wait_done(input int limit, input int spurious_at, output int waited);
        waited = -1;
        for (int c = 0; c < limit; c++) begin
            if (done) begin
                waited = c;
                break;
            end
            if (c == spurious_at) begin
                start     = 1'b1;
                num_words = '0;
                base_addr = 13'h0AAA;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check_val("done_seen", 64'(waited >= 0), 64'd1);
    endtask

    task automatic finish_checks(input logic exp_pass, input logic [15:0] exp_err);
        check_val("pass", 64'(pass), 64'(exp_pass));
        check_val("err_count", 64'(err_count), 64'(exp_err));
        check_val("busy_at_done", 64'(busy), 64'd0);
        @(negedge clk);
        check_val("done_width", 64'(done), 64'd0);
        check_val("pass_hold", 64'(pass), 64'(exp_pass));
        @(negedge clk);
        check_val("done_count", 64'(done_cnt), 64'd1);
        check_val("bus_proto", 64'(proto_err), 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_busy"},  64'(busy), 64'd0);
        check_val({tag, "_done"},  64'(done), 64'd0);
        check_val({tag, "_pass"},  64'(pass), 64'd0);
        check_val({tag, "_err"},   64'(err_count), 64'd0);
        check_val({tag, "_cmd"},   64'({avm_read, avm_write, avm_chipselect}), 64'd0);
        check_val({tag, "_addr"},  64'(avm_address), 64'd0);
        check_val({tag, "_wdata"}, avm_writedata, 64'd0);
        check_val({tag, "_be"},    64'(avm_byteenable), 64'd0);
`ifdef HPS_FPGA_MEM_TESTER_ERR_CAPTURE_EN
        check_val({tag, "_ferr_addr"}, 64'(first_err_addr), 64'd0);
        check_val({tag, "_ferr_data"}, first_err_data, 64'd0);
`endif
    endtask

    // -------------------------------------------------------------- stimulus
    initial begin
        int w;
        int bad;
        reset_n = 1'b0; start = 1'b0;
        base_addr = '0; num_words = '0; seed = '0;
        avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0; avm_readdata = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset_n = 1'b1;
        @(negedge clk);

        // Ideal memory: 0x100..0x107 to addresses 0..7, back-to-back reads.
        lat = 1; wait_en = 1'b0;
        start_test(13'h0000, 14'd8, 64'h100);
        wait_done(200, -1, w);
        finish_checks(1'b1, 16'd0);
        check_val("t1_wr0_data", wr_log_data[0], 64'h100);
        check_val("t1_wr7_data", wr_log_data[7], 64'h107);
        check_val("t1_wr7_addr", 64'(wr_log_addr[7]), 64'h7);
        check_val("t1_writes", 64'(wr_k), 64'd8);
        check_val("t1_reads", 64'(rd_k), 64'd8);
        check_val("t1_rd_burst", 64'(last_rd_cyc - first_rd_cyc), 64'd7);
        check_val("t1_wr_to_rd", 64'(first_rd_cyc - last_wr_cyc), 64'd1);

        // Address wrap at the top of memory.
        start_test(13'h1FFE, 14'd4, 64'h55);
        wait_done(200, -1, w);
        finish_checks(1'b1, 16'd0);
        check_val("t2_wr0", 64'(wr_log_addr[0]), 64'h1FFE);
        check_val("t2_wr1", 64'(wr_log_addr[1]), 64'h1FFF);
        check_val("t2_wr2", 64'(wr_log_addr[2]), 64'h0000);
        check_val("t2_wr3", 64'(wr_log_addr[3]), 64'h0001);
        check_val("t2_rd0", 64'(rd_log_addr[0]), 64'h1FFE);
        check_val("t2_rd2", 64'(rd_log_addr[2]), 64'h0000);
        check_val("t2_rd3", 64'(rd_log_addr[3]), 64'h0001);

        // Bit 0 of word 3 corrupted on read.
        flip_en = 1'b1;
        start_test(13'h0020, 14'd8, 64'hABCD);
        wait_done(200, -1, w);
        finish_checks(1'b0, 16'd1);
`ifdef HPS_FPGA_MEM_TESTER_ERR_CAPTURE_EN
        check_val("t3_ferr_addr", 64'(first_err_addr), 64'h23);
        check_val("t3_ferr_data", first_err_data, 64'hABD1);
`endif
        flip_en = 1'b0;

        // Random waitrequest, 3-cycle latency, start pulse while busy.
        wait_en = 1'b1; lat = 3;
        start_test(13'h0100, 14'd64, 64'h0123_4567_89AB_CDEF);
        wait_done(3000, 10, w);
        finish_checks(1'b1, 16'd0);
        check_val("t4_max_pend_le4", 64'(max_pend <= 4), 64'd1);
        check_val("t4_writes", 64'(wr_k), 64'd64);
        check_val("t4_reads", 64'(rd_k), 64'd64);

        // Long latency: throttled at exactly MAX_PEND; seed wraps past 2^64.
        wait_en = 1'b0; lat = 6;
        start_test(13'h0040, 14'd32, 64'hFFFF_FFFF_FFFF_FFF0);
        wait_done(1000, -1, w);
        finish_checks(1'b1, 16'd0);
        check_val("t5_max_pend", 64'(max_pend), 64'd4);

        // Empty test: done the cycle after start, no bus traffic.
        lat = 1;
        start_test(13'h0010, 14'd0, 64'h5);
        wait_done(20, -1, w);
        check_val("t6_latency", 64'(w), 64'd0);
        finish_checks(1'b1, 16'd0);
        check_val("t6_bus_act", 64'(bus_act), 64'd0);

        // Full depth: every word written and read exactly once.
        start_test(13'h0005, 14'h2000, 64'h77);
        wait_done(20000, -1, w);
        finish_checks(1'b1, 16'd0);
        bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((wr_hits[i] != 1) || (rd_hits[i] != 1)) bad++;
        end
        check_val("t7_touch_once", 64'(bad), 64'd0);
        check_val("t7_writes", 64'(wr_k), 64'd8192);

        // Reset in the middle of the read phase.
        lat = 3;
        start_test(13'h0000, 14'd64, 64'h900);
        for (int c = 0; (c < 500) && (rd_k < 5); c++) @(negedge clk);
        check_val("t8_in_read", 64'(rd_k >= 5), 64'd1);
        reset_n = 1'b0;
        @(negedge clk);
        check_all_zero("t8_abort");
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        check_val("t8_no_done", 64'(done_cnt), 64'd0);
        check_val("t8_idle_busy", 64'(busy), 64'd0);
        check_val("t8_idle_err", 64'(err_count), 64'd0);
        check_val("t8_flushed", 64'(pend), 64'd0);

        // Normal operation after the abort.
        start_test(13'h0300, 14'd16, 64'h42);
        wait_done(500, -1, w);
        finish_checks(1'b1, 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hps_fpga_mem_tester.md
HPS_FPGA_MEM_TESTER -- requirements
Module: hps_fpga_mem_tester

Interface
REQ-001 SHALL have parameter ADDR_W, default 13, word-address width of the target memory.
REQ-002 SHALL have parameter DATA_W, default 64, data width (multiple of 8).
REQ-003 SHALL have parameter MAX_PEND, default 4, maximum outstanding reads (power of 2, 1..16).
REQ-004 SHALL have port clk, input, 1, the only clock; all logic is on its rising edge.
REQ-005 SHALL have port reset_n, input, 1, reset, synchronous and active-low.
REQ-006 SHALL have port start, input, 1, single-cycle pulse that launches a test.
REQ-007 SHALL have port base_addr, input, ADDR_W, first word address; sampled on accepted start.
REQ-008 SHALL have port num_words, input, ADDR_W+1, word count 0..2^ADDR_W; sampled on accepted start.
REQ-009 SHALL have port seed, input, DATA_W, pattern seed; sampled on accepted start.
REQ-010 SHALL have ports busy, done, and pass, each output, 1: test running; one-cycle completion pulse; result valid from done until next start.
REQ-011 SHALL have port err_count, output, 16, number of mismatching words, saturating.
REQ-012 SHALL have Avalon-MM master ports avm_address (out, ADDR_W), avm_chipselect (out, 1), avm_read (out, 1), avm_write (out, 1), avm_byteenable (out, DATA_W/8), avm_writedata (out, DATA_W), avm_readdata (in, DATA_W), avm_waitrequest (in, 1), and avm_readdatavalid (in, 1).

Function
REQ-013 SHALL implement FSM IDLE -> WRITE -> READ -> DRAIN -> DONE -> IDLE.
REQ-014 SHALL accept start only in IDLE; start in any other state SHALL be ignored.
REQ-015 SHALL go from accepted start with num_words=0 to DONE, so that done=1 and pass=1 on the following cycle with no bus transfers.
REQ-016 SHALL, in WRITE, present word i with avm_address=(base_addr+i) mod 2^ADDR_W, avm_writedata=(seed+i) mod 2^DATA_W, and avm_byteenable all ones.
REQ-017 SHALL hold the command stable while avm_waitrequest=1, and SHALL advance i only on a cycle with avm_write=1 and avm_waitrequest=0.
REQ-018 SHALL, after the last write is accepted, enter READ with i=0 on the next cycle, with no idle cycle required.
REQ-019 SHALL, in READ, issue reads to the same address sequence.
REQ-020 SHALL issue a read only while outstanding count < MAX_PEND; the count SHALL increment on an accepted read and decrement on avm_readdatavalid, both in the same cycle if simultaneous.
REQ-021 SHALL compare responses in order against (seed+k), where k is a separate response index.
REQ-022 SHALL increment err_count per mismatch, saturating at 16'hFFFF.
REQ-023 SHALL enter DRAIN after the last read is accepted, and SHALL exit to DONE when all num_words responses have been received.
REQ-024 SHALL assert done for exactly one cycle in DONE, with pass=(err_count==0); busy SHALL be 1 in WRITE, READ, and DRAIN only.
REQ-025 SHALL assert avm_chipselect exactly when avm_read or avm_write is 1; avm_read and avm_write SHALL never be 1 together.
REQ-026 SHALL ignore avm_readdatavalid in IDLE, WRITE, and DONE.
REQ-027 SHALL wrap the address past 2^ADDR_W-1 to 0; a full-depth test SHALL touch every word exactly once per phase.
REQ-028 SHALL support read latency of 1 or more cycles, and SHALL sustain one read per cycle at latency 1 with avm_waitrequest=0.

Reset
REQ-029 SHALL, while reset_n=0 at a clock edge, force IDLE and clear busy, done, pass, err_count, avm_read, avm_write, avm_chipselect, the outstanding count, and the indices; avm_address, avm_writedata, and avm_byteenable SHALL be 0.
REQ-030 SHALL abort any in-progress test on reset with no done pulse; late responses after reset SHALL be ignored.

Configuration
REQ-031 SHALL, with macro HPS_FPGA_MEM_TESTER_ERR_CAPTURE_EN defined, add outputs first_err_addr (ADDR_W) and first_err_data (DATA_W), which capture the address and read data of the first mismatch of each test.
REQ-032 SHALL clear these capture outputs on accepted start and on reset, and SHALL hold them until the next start.
REQ-033 SHALL, without HPS_FPGA_MEM_TESTER_ERR_CAPTURE_EN, have neither these ports nor the capture logic.

Structure
REQ-034 SHALL place the FSM state enum and the err_count width/saturation constant in shared package hps_fpga_mem_tester_pkg.
REQ-035 SHALL use one sub-module, hps_fpga_mem_tester_cmp, holding the response index, pattern compare, and saturating error counter.

Verification
REQ-036 SHALL cover: base=0, num=8, seed=0x100, ideal 1-cycle memory -> writes of 0x100..0x107 to addresses 0..7, then done, pass=1, err_count=0.
REQ-037 SHALL cover: base=0x1FFE, num=4 -> addresses 0x1FFE, 0x1FFF, 0x0000, 0x0001 in both phases.
REQ-038 SHALL cover: memory model flipping bit 0 of word 3 -> err_count=1, pass=0; with ERR_CAPTURE_EN, first_err_addr=base+3.
REQ-039 SHALL cover: random waitrequest plus 3-cycle read latency, MAX_PEND=4, num=64 -> pass=1 and never more than 4 reads outstanding.
REQ-040 SHALL cover: num=0 -> done on the next cycle with pass=1 and no bus activity; start while busy -> ignored.
REQ-041 SHALL cover: reset_n=0 mid-READ -> the next cycle is IDLE, all outputs are 0, and no done pulse occurs.
